// File: rtl/mod_reduce_257.sv
// Word-serial reducer: subtracts the modulus one word per cycle, up to MAX_PASS times.
// Optional MOD_REDUCE_BYPASS_EN adds in_bypass to pass the sum straight through.
module mod_reduce_257 #(
    parameter int WIDTH    = 256,
    parameter int WORD     = 64,
    parameter int MAX_PASS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_mod,
`ifdef MOD_REDUCE_BYPASS_EN
    input  logic             in_bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_ovf
);

    localparam int NW = WIDTH / WORD;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(MAX_PASS + 1);
    localparam logic [KW-1:0] KLAST = KW'(NW - 1);
    localparam logic [CW-1:0] CMAX  = CW'(MAX_PASS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH:0]   x;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] d;
    logic [KW-1:0]    k;
    logic             borrow;
    logic [CW-1:0]    sub_cnt;

    logic [WORD-1:0]  xw;
    logic [WORD-1:0]  mw;
    logic [WORD:0]    wd;
    logic [WIDTH-1:0] d_next;
    logic             bfin;
    logic             last;
    logic             ge;
    logic             bypass;

`ifdef MOD_REDUCE_BYPASS_EN
    assign bypass = in_bypass;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // One word of the running subtraction; the top bit of wd is the borrow out.
    always_comb begin
        xw     = x[k*WORD +: WORD];
        mw     = m[k*WORD +: WORD];
        wd     = {1'b0, xw} - {1'b0, mw} - {{WORD{1'b0}}, borrow};
        d_next = d;
        d_next[k*WORD +: WORD] = wd[WORD-1:0];
        bfin   = wd[WORD];
        last   = (k == KLAST);
        ge     = x[WIDTH] | ~bfin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            x       <= '0;
            m       <= '0;
            d       <= '0;
            k       <= '0;
            borrow  <= 1'b0;
            sub_cnt <= '0;
            out_res <= '0;
            out_ovf <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (in_valid) begin
                        x       <= in_sum;
                        m       <= in_mod;
                        k       <= '0;
                        borrow  <= 1'b0;
                        sub_cnt <= '0;
                        if (bypass) begin
                            state   <= S_DONE;
                            out_res <= in_sum[WIDTH-1:0];
                            out_ovf <= in_sum[WIDTH];
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                (state == S_RUN): begin
                    d <= d_next;
                    if (!last) begin
                        k      <= k + 1'b1;
                        borrow <= bfin;
                    end else begin
                        k      <= '0;
                        borrow <= 1'b0;
                        if (!ge) begin
                            state   <= S_DONE;
                            out_res <= x[WIDTH-1:0];
                            out_ovf <= 1'b0;
                        end else if (sub_cnt < CMAX) begin
                            // top bit of X minus final borrow is a 1-bit XOR
                            x       <= {x[WIDTH] ^ bfin, d_next};
                            sub_cnt <= sub_cnt + 1'b1;
                        end else begin
                            state   <= S_DONE;
                            out_res <= x[WIDTH-1:0];
                            out_ovf <= 1'b1;
                        end
                    end
                end
                (state == S_DONE): begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_257.sv
// Scoreboard bench for mod_reduce_257: directed vectors, monitor checks
// residue, overflow flag and accept-to-valid latency.
module tb_mod_reduce_257;

    localparam int W = 256;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W:0]   in_sum = '0;
    logic [W-1:0] in_mod = '0;
    logic         in_bypass = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_res;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    logic prev_v = 1'b0;

    mod_reduce_257 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_mod    (in_mod),
`ifdef MOD_REDUCE_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W:0] act,
                       input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: record accepts, check each new result against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
        if (rst_n && out_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {1'b0, out_res}, '0);
            end else begin
                exp_t e;
                int a;
                e = exp_q.pop_front();
                a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                chk("res", {1'b0, out_res}, {1'b0, e.res});
                chk("ovf", {{W{1'b0}}, out_ovf}, {{W{1'b0}}, e.ovf});
                chk("latency", (W+1)'(cyc - a), (W+1)'(e.lat));
            end
        end
        prev_v = out_valid;
    end

    task automatic send(input logic [W:0] s, input logic [W-1:0] m,
                        input logic byp, input logic track,
                        input logic [W-1:0] r, input logic o, input int lat);
        int n;
        exp_t e;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_sum    = s;
        in_mod    = m;
        in_bypass = byp;
        if (track) begin
            e.res = r; e.ovf = o; e.lat = lat;
            exp_q.push_back(e);
        end
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("drain_timeout", (W+1)'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        int hs;
        logic [W:0] big;
        logic [W-1:0] ones;
        big  = {1'b1, 256'd1};
        ones = '1;

        #12;
        chk("rst_valid", {{W{1'b0}}, out_valid}, 0);
        chk("rst_res", {1'b0, out_res}, 0);
        chk("rst_ovf", {{W{1'b0}}, out_ovf}, 0);
        chk("rst_ready", {{W{1'b0}}, in_ready}, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(5, 7, 0, 1, 5, 0, 4);
        send(10, 7, 0, 1, 3, 0, 8);
        send(big, ones, 0, 1, 2, 0, 8);
        send(20, 7, 0, 1, 6, 0, 12);
        send(22, 7, 0, 1, 8, 1, 12);
        send(9, 0, 0, 1, 9, 1, 12);
        drain();

        // Backpressure with a new request held pending.
        out_ready = 1'b0;
        send(15, 7, 0, 1, 1, 0, 12);
        in_valid = 1'b1;
        in_sum   = 5;
        in_mod   = 7;
        begin
            exp_t e;
            e.res = 5; e.ovf = 0; e.lat = 4;
            exp_q.push_back(e);
        end
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("bp_timeout", 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res", {1'b0, out_res}, 1);
            chk("bp_ovf", {{W{1'b0}}, out_ovf}, 0);
            chk("bp_valid", {{W{1'b0}}, out_valid}, 1);
            chk("bp_in_ready", {{W{1'b0}}, in_ready}, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        hs = cyc + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 10);
        chk("turnaround", (W+1)'(cyc + 1), (W+1)'(hs + 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of the first pass.
        send(20, 7, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {{W{1'b0}}, out_valid}, 0);
        chk("abort_res", {1'b0, out_res}, 0);
        chk("abort_ovf", {{W{1'b0}}, out_ovf}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_q.delete();
        chk("abort_ready", {{W{1'b0}}, in_ready}, 1);
        repeat (20) @(posedge clk);
        chk("abort_silent", {{W{1'b0}}, out_valid}, 0);
        send(14, 7, 0, 1, 0, 0, 12);
        drain();

`ifdef MOD_REDUCE_BYPASS_EN
        send({1'b1, 256'd3}, 7, 1, 1, 3, 1, 1);
        drain();
`endif

        chk("scoreboard_empty", (W+1)'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
